uart_tx: RTL
============

// Module: uart_tx
// PURPOSE
//   UART serializer; the transmit counterpart of uart_rx and the stage that drives its i_rx line.
//   Accepts WIDTH-bit words on a valid/ready handshake.
//   Emits 8N1-style frames, LSB first, on o_tx: start(0), WIDTH data bits, stop(1).
//   Line idles high. One bit period = DIVISOR clk cycles, using the same DIVISOR convention as uart_rx.
// PARAMETERS
//   WIDTH       8    data bits per frame (>=1)
//   DIVISOR     86   clk cycles per bit (>=2); 10 MHz / 115200 baud
//   PARITY_ODD  0    parity sense when UART_TX_PARITY_EN is defined: 0=even, 1=odd
// PORTS
//   clk           in   1      system clock; all logic on posedge
//   i_reset_n     in   1      synchronous, active-low reset
//   i_data        in   WIDTH  word to send; sampled only on accept
//   i_data_valid  in   1      upstream has a word
//   o_ready       out  1      block can accept a word this cycle
//   o_tx          out  1      serial line, registered, idle high
//   o_busy        out  1      frame in progress (start..stop)
// BEHAVIOUR
//   Reset (i_reset_n=0 at a posedge) takes effect on that edge, including mid-frame:
//     o_tx=1, o_busy=0, state=IDLE, counters=0; o_ready=1 from the next cycle.
//     An aborted frame is not resumed.
//   Accept: i_data_valid && o_ready at a posedge.
//     i_data is latched into a shift register and the baud counter is cleared.
//   States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or STOP -> START on accept.
//   Latency: accept at edge t -> o_tx=0 (start bit) from t+1. o_busy=1 from t+1.
//   Bit timing:
//     Every bit, including start and stop, is held for exactly DIVISOR cycles.
//     Baud counter is $clog2(DIVISOR) bits wide and counts 0..DIVISOR-1.
//     The state/bit advances when the counter hits DIVISOR-1.
//   DATA: the shift register shifts right and o_tx <= shreg[0].
//     Bit counter is $clog2(WIDTH+1) bits wide and runs 0..WIDTH-1; it wraps to 0 on leaving DATA.
//   o_ready = (state==IDLE) || (state==STOP && baud_cnt==DIVISOR-1).
//     This is a combinational decode of registers; it does not depend on i_data_valid.
//   Back-to-back: an accept in the last stop cycle starts the next start bit on the following edge.
//     There is no idle gap between frames; frame period = (WIDTH+2)*DIVISOR cycles.
//   Words with i_data_valid high while o_ready=0 are ignored and never latched.
//     Upstream must hold valid until accepted.
//   Ending a frame with no new accept: o_tx stays 1, o_busy drops to 0 on the edge that leaves STOP.
// CONFIGURATION
//   UART_TX_PARITY_EN defined:
//     A PARITY state is inserted after DATA for DIVISOR cycles.
//     Bit value = ^data (even) or ~^data (odd) per PARITY_ODD, computed at accept.
//     Frame period = (WIDTH+3)*DIVISOR.
//   UART_TX_PARITY_EN undefined: no PARITY state or logic; PARITY_ODD is ignored.
// STRUCTURE
//   uart_pkg:
//     typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
//     UART_START_BIT=1'b0, UART_STOP_BIT=1'b1, UART_IDLE=1'b1.
//     Shared with uart_rx.
//   Sub-module uart_baud_gen (params DIVISOR; ports clk, i_reset_n, i_clear, o_tick):
//     o_tick is high on count DIVISOR-1; i_clear restarts the count at 0.
//   FSM, shift register and bit counter live in uart_tx.
// TESTING
//   1. WIDTH=8, DIVISOR=4, send 0xA5.
//      Expect o_tx = 0,1,0,1,0,0,1,0,1,1, each held 4 clk, starting the clk after accept.
//      o_busy high for 40 clk.
//   2. 0x00 then 0xFF back-to-back, valid held high, DIVISOR=4.
//      Second accept lands in the last stop cycle; 80 clk of frames with no idle cycle between them.
//   3. Reset mid-frame: deassert i_reset_n during data bit 3 of 0x3C.
//      Expect o_tx=1 and o_busy=0 after that edge, o_ready=1 next cycle.
//      A subsequent 0x81 is sent intact.
//   4. Valid toggling: raise i_data_valid with 0x11 while busy, change to 0x22, then hold until accept.
//      Only 0x22 is transmitted.
//   5. Loopback into uart_rx (DIVISOR=86, SAMPLE_PHASE=43).
//      Send 1024 random bytes; the received o_data sequence must equal the sent sequence, 0 errors.
//   6. UART_TX_PARITY_EN, PARITY_ODD=0: send 0xA5.
//      Parity bit = 0, stop follows, frame = 11*DIVISOR clk.
//      With PARITY_ODD=1: parity bit = 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and line levels.
// Used by uart_tx and uart_rx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam logic UART_IDLE      = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIVISOR-1.
// o_tick marks the last cycle of each bit period.
module uart_baud_gen #(
  parameter int DIVISOR = 86
) (
  input  logic clk,
  input  logic i_reset_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART serializer: start, WIDTH data bits LSB first, stop.
// Define UART_TX_PARITY_EN to insert a parity bit before stop.
module uart_tx #(
  parameter int WIDTH      = 8,
  parameter int DIVISOR    = 86,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_data_valid,
  output logic             o_ready,
  output logic             o_tx,
  output logic             o_busy
);

  import uart_pkg::*;

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);

  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
  end

  uart_state_t      r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [BW-1:0]    r_bitcnt;
  logic             r_tx;
  logic             r_busy;
  logic             w_tick;
  logic             w_accept;
`ifdef UART_TX_PARITY_EN
  logic             r_par;
`endif

  // Ready also in the final stop cycle so frames can abut
  assign o_ready  = (r_state == IDLE) ||
                    (r_state == STOP && w_tick);
  assign w_accept = i_data_valid && o_ready;
  assign o_tx     = r_tx;
  assign o_busy   = r_busy;

  uart_baud_gen #(
    .DIVISOR(DIVISOR)
  ) u_baud (
    .clk      (clk),
    .i_reset_n(i_reset_n),
    .i_clear  (w_accept),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_tx     <= UART_IDLE;
      r_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state  <= START;
      r_shreg  <= i_data;
      r_bitcnt <= '0;
      r_tx     <= UART_START_BIT;
      r_busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par    <= (^i_data) ^ (PARITY_ODD != 0);
`endif
    end else if (w_tick) begin
      unique case (r_state)
        IDLE: begin
        end
        START: begin
          r_state <= DATA;
          r_tx    <= r_shreg[0];
          r_shreg <= r_shreg >> 1;
        end
        DATA: begin
          if (r_bitcnt == BLAST) begin
            r_bitcnt <= '0;
`ifdef UART_TX_PARITY_EN
            r_state  <= PARITY;
            r_tx     <= r_par;
`else
            r_state  <= STOP;
            r_tx     <= UART_STOP_BIT;
`endif
          end else begin
            r_bitcnt <= r_bitcnt + BW'(1);
            r_tx     <= r_shreg[0];
            r_shreg  <= r_shreg >> 1;
          end
        end
        PARITY: begin
          r_state <= STOP;
          r_tx    <= UART_STOP_BIT;
        end
        STOP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_tx    <= UART_IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_tx    <= UART_IDLE;
        end
      endcase
    end
  end

endmodule
